intr_dispatch: RTL
==================

Name: intr_dispatch

Overview:
Downstream consumer of the 4-source priority interrupt encoder (intr + 2-bit source index x). Captures each encoded request into a sticky per-source pending register and applies a per-source mask. Presents one request at a time to the CPU side with an irq/ack/eoi handshake, and keeps a saturating service count per source. Sits between the encoder and the core's interrupt entry logic.

Parameters:
CNT_W, 8, width of each per-source service counter (saturating)
TIMEOUT, 16, cycles in REQ without ack before withdrawing irq_o (>=2)

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
intr_i  in  1  request valid from encoder
x_i  in  2  source index from encoder, meaningful only when intr_i=1
mask_i  in  4  per-source mask, 1 = ignore requests from that source
ack_i  in  1  CPU accepts presented vector
eoi_i  in  1  CPU end-of-interrupt
cnt_sel_i  in  2  selects counter shown on cnt_o
irq_o  out  1  interrupt request to CPU
vec_o  out  2  source index being requested/serviced
busy_o  out  1  a source is in service
pend_o  out  4  pending register
cnt_o  out  CNT_W  service count of source cnt_sel_i
drop_o  out  1  one-cycle pulse: request hit an already-pending source
tmo_o  out  1  one-cycle pulse: REQ timed out

Behaviour:
- One clock; reset is asynchronous and active-low (clk_i, rst_ni). Async assert, sync release assumed upstream.
- Reset values: state=IDLE, pend=0, all counters=0, timer=0, irq_o=0, vec_o=0, busy_o=0, drop_o=0, tmo_o=0.
- Capture: on each edge, if intr_i=1 and mask_i[x_i]=0 -> pend[x_i]<=1. If pend[x_i] was already 1 -> drop_o=1 next cycle. Masked requests are discarded, with no drop pulse.
- Mask changes affect capture only; bits already pending are never cleared by the mask.
- Selection: the highest set index of pend wins (3 highest, 0 lowest).
- FSM (Moore outputs, registered):
  IDLE: irq_o=0, busy_o=0. If pend!=0 -> REQ; vec<=selected index; timer<=0.
  REQ: irq_o=1, vec_o frozen (a later higher-priority arrival does not preempt). ack_i=1 -> SERV, clear pend[vec], cnt[vec]+=1 (saturate at 2^CNT_W-1). Otherwise timer++. timer==TIMEOUT-1 without ack -> IDLE, tmo_o pulse, pend retained.
  SERV: irq_o=0, busy_o=1, vec_o held. eoi_i=1 -> IDLE.
- Ignored: ack_i outside REQ; eoi_i outside SERV.
- Latency: intr_i sampled at edge k -> pend set after k -> irq_o high after edge k+1 (2 edges). ack at edge m -> irq_o low, busy_o high after m.
- Simultaneous set and clear of the same pend bit (new request for vec on the ack edge): set wins, the bit stays 1, and drop_o is not pulsed.
- Back-to-back: eoi at edge e with pend!=0 -> IDLE after e, REQ after e+1.
- cnt_o is combinational from cnt_sel_i over the counter registers.
- rst_ni low mid-operation: immediately return to reset values, including pend and counters.

Test Plan:
- Reset: rst_ni=0 for 100 ns, then drive intr_i=1,x_i=2 -> irq_o, pend_o, cnt_o all 0 until release; after release, pend_o=4'b0100 one edge later, irq_o=1 and vec_o=2 one edge after that.
- Handshake: single request x=1; ack 3 cycles after irq_o -> irq_o=0, busy_o=1, pend_o=0, cnt(1)=1; eoi -> busy_o=0, IDLE.
- Priority/no preemption: pend sources 0 and 2 -> vec_o=2 first; inject x=3 during REQ -> vec_o stays 2; after eoi, next vec_o=3, then 0.
- Mask and drop: mask_i=4'b0001 with intr x=0 -> pend_o unchanged, no drop_o. Two requests x=1 while pend[1]=1 -> drop_o pulses twice.
- Timeout: TIMEOUT=16, no ack -> irq_o drops after 16 cycles, tmo_o one-cycle pulse, pend retained; re-enters REQ 1 cycle later.
- Saturation and edge cases: CNT_W=2, service source 3 five times -> cnt_o=3. Pulse rst_ni low during SERV -> all outputs 0 at once.

Source files
------------

// File: rtl/intr_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : intr_dispatch
// Purpose  : Captures encoded interrupt requests into a sticky, maskable
//            pending register and hands them to the CPU one at a time over an
//            irq/ack/eoi handshake, keeping a saturating count per source.
// Revision : 1.0 - initial release
// ============================================================================
module intr_dispatch #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             intr_i,
   input  logic [1:0]       x_i,
   input  logic [3:0]       mask_i,
   input  logic             ack_i,
   input  logic             eoi_i,
   input  logic [1:0]       cnt_sel_i,
   output logic             irq_o,
   output logic [1:0]       vec_o,
   output logic             busy_o,
   output logic [3:0]       pend_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             drop_o,
   output logic             tmo_o
);

   localparam int                 c_timer_w  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_timer_w-1:0] c_tmo_last = c_timer_w'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   c_cnt_max  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [1:0]             r_vec, w_vec_nxt;
   logic [c_timer_w-1:0]   r_timer, w_timer_nxt;
   logic                   r_tmo, w_tmo_nxt;
   logic                   r_drop, w_drop_nxt;
   logic [3:0]             r_pend, w_pend_nxt;
   logic [3:0]             w_set_mask, w_clr_mask;
   logic [1:0]             w_sel;
   logic [CNT_W-1:0]       r_cnt [4];

   // Decode an unmasked encoder request and an accepted vector into one-hot set/clear masks
   always_comb begin
      w_set_mask = 4'b0000;
      w_clr_mask = 4'b0000;
      if (intr_i && !mask_i[x_i])
         w_set_mask[x_i] = 1'b1;
      if (r_state == ST_REQ && ack_i)
         w_clr_mask[r_vec] = 1'b1;
   end

   // Set beats clear on the same bit; a collision with a bit that survives the edge is a drop
   assign w_pend_nxt = (r_pend & ~w_clr_mask) | w_set_mask;
   assign w_drop_nxt = |(w_set_mask & r_pend & ~w_clr_mask);

   // Fixed priority: highest pending index wins
   always_comb begin
      w_sel = 2'd0;
      if (r_pend[3])      w_sel = 2'd3;
      else if (r_pend[2]) w_sel = 2'd2;
      else if (r_pend[1]) w_sel = 2'd1;
      else                w_sel = 2'd0;
   end

   // Dispatch FSM next-state: vector is latched on REQ entry and frozen until IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_timer_nxt = r_timer;
      w_tmo_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pend != 4'b0000) begin
               w_state_nxt = ST_REQ;
               w_vec_nxt   = w_sel;
               w_timer_nxt = '0;
            end
         end
         ST_REQ: begin
            if (ack_i) begin
               w_state_nxt = ST_SERV;
            end else if (r_timer == c_tmo_last) begin
               // Withdraw irq but keep the source pending so it is re-offered
               w_state_nxt = ST_IDLE;
               w_tmo_nxt   = 1'b1;
            end else begin
               w_timer_nxt = r_timer + c_timer_w'(1);
            end
         end
         ST_SERV: begin
            if (eoi_i)
               w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM, pending register and pulse outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_vec   <= 2'd0;
         r_timer <= '0;
         r_tmo   <= 1'b0;
         r_drop  <= 1'b0;
         r_pend  <= 4'b0000;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_timer <= w_timer_nxt;
         r_tmo   <= w_tmo_nxt;
         r_drop  <= w_drop_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // Per-source service counters, bumped when the source is accepted, saturating at all-ones
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++)
            r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (w_clr_mask[i] && r_cnt[i] != c_cnt_max)
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
   end

   assign irq_o  = (r_state == ST_REQ);
   assign busy_o = (r_state == ST_SERV);
   assign vec_o  = r_vec;
   assign pend_o = r_pend;
   assign drop_o = r_drop;
   assign tmo_o  = r_tmo;
   assign cnt_o  = r_cnt[cnt_sel_i];

endmodule
`default_nettype wire
